npc_sched: RTL and testbench
============================

NPC_SCHED -- requirements
Module: npc_sched

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the boot fetch address.
REQ-002 SHALL have parameter EXC_ENTRY, default 32'h0000_4180, meaning the exception handler entry.
REQ-003 SHALL have port i_clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 SHALL have port i_pc, input, 32 bits, meaning the current F-stage PC.
REQ-006 SHALL have port i_stall, input, 1 bit, meaning a hazard stall that freezes F.
REQ-007 SHALL have port i_imem_ready, input, 1 bit, meaning instruction memory accepts a new fetch this cycle.
REQ-008 SHALL have ports i_br_taken, input, 1 bit, and i_br_target, input, 32 bits, meaning a D-stage branch/jump redirect.
REQ-009 SHALL have ports i_req, input, 1 bit, and i_eret, input, 1 bit, meaning an exception/interrupt request and an ERET.
REQ-010 SHALL have port i_epc, input, 32 bits, meaning the ERET return address.
REQ-011 SHALL have ports o_npc, output, 32 bits, and o_pc_en, output, 1 bit, meaning the PC load value and PC load enable.
REQ-012 SHALL have port o_state, output, 2 bits, meaning the current FSM state, for debug.

Function
REQ-013 SHALL implement FSM states BOOT=0, RUN=1, HOLD=2; encoding 3 unused, decoding to BOOT.
REQ-014 In BOOT: o_npc=PC_RESET, o_pc_en=1; next state RUN unconditionally.
REQ-015 In RUN/HOLD, o_npc SHALL be selected by priority: i_req -> EXC_ENTRY; else i_eret -> i_epc; else pending valid -> pend_target; else i_br_taken -> i_br_target; else i_pc+4 (mod 2^32).
REQ-016 i_req or i_eret SHALL force o_pc_en=1 regardless of i_stall/i_imem_ready, and SHALL clear any pending redirect.
REQ-017 Otherwise, o_pc_en SHALL be 1 only when i_stall=0 and i_imem_ready=1.
REQ-018 i_br_taken=1 while o_pc_en=0 and no i_req/i_eret SHALL latch pend_target<=i_br_target, set pend_valid, and enter HOLD; a later redirect while already pending SHALL be ignored.
REQ-019 In HOLD, the first cycle with o_pc_en=1 SHALL output pend_target, clear pend_valid, and return to RUN.
REQ-020 Redirect latency SHALL be zero cycles combinationally: the target appears on o_npc in the same cycle and is loaded at that cycle's edge when enabled.
REQ-021 i_req and i_eret asserted together SHALL resolve to i_req (EXC_ENTRY).

Reset
REQ-022 i_reset_n=0 SHALL asynchronously force state=BOOT, pend_valid=0, pend_target=0, and o_npc=PC_RESET, o_pc_en=1.
REQ-023 Reset mid-HOLD SHALL discard the pending redirect; the first fetch after release SHALL be PC_RESET.

Configuration
REQ-024 With NPC_PERF_CNT_EN defined: SHALL add output o_redir_cnt, 32 bits, counting cycles where o_pc_en=1 and o_npc != i_pc+4, excluding BOOT; wraps at 2^32; reset 0.
REQ-025 Without NPC_PERF_CNT_EN: the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-026 State encodings, PC_RESET and EXC_ENTRY defaults SHALL live in the shared definitions header alongside the existing PC default.
REQ-027 The pending redirect register SHALL be one sub-module, npc_pend_buf (valid+target, set/clear/priority-clear).

Verification
REQ-028 Release reset, i_pc=0x3000, stall=0, ready=1 -> cycle 0 BOOT o_npc=0x3000; cycle 1 RUN o_npc=0x3004, o_pc_en=1.
REQ-029 i_br_taken=1, target=0x3100, stall=1 for 2 cycles -> HOLD, o_pc_en=0; stall drops -> o_npc=0x3100, o_pc_en=1, then RUN.
REQ-030 Pending 0x3100 in HOLD, i_req=1 with stall=1 -> o_npc=0x4180, o_pc_en=1, pend cleared, next cycle RUN with o_npc=i_pc+4.
REQ-031 i_req=1 and i_eret=1 with i_epc=0x3020 -> o_npc=0x4180; i_eret alone -> o_npc=0x3020 even with i_imem_ready=0.
REQ-032 i_pc=0xFFFF_FFFC, no events -> o_npc=0x0000_0000; assert i_reset_n=0 mid-HOLD -> immediately BOOT, o_npc=0x3000.
REQ-033 With NPC_PERF_CNT_EN: one branch, one exception, and 10 sequential fetches -> o_redir_cnt=2.

Source files
------------

// File: rtl/npc_sched_pkg.sv
// Shared definitions for the next-PC scheduler: state encodings, address defaults and
// the sequential-PC helper.
package npc_sched_pkg;

  localparam logic [31:0] PcDefault       = 32'h0000_3000;
  localparam logic [31:0] PcResetDefault  = PcDefault;
  localparam logic [31:0] ExcEntryDefault = 32'h0000_4180;
  localparam logic [31:0] PcStep          = 32'd4;

  // Encoding 2'd3 is unused and behaves as StBoot.
  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } npc_state_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PcStep;
  endfunction

endpackage

// File: rtl/npc_sched_if.sv
// Fetch-side signal bundle for npc_sched. Defining NPC_PERF_CNT_EN adds the
// redirect-count output.
interface npc_sched_if;

  logic [31:0] i_pc;
  logic        i_stall;
  logic        i_imem_ready;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        i_req;
  logic        i_eret;
  logic [31:0] i_epc;
  logic [31:0] o_npc;
  logic        o_pc_en;
  logic [1:0]  o_state;
`ifdef NPC_PERF_CNT_EN
  logic [31:0] o_redir_cnt;

  modport master (
    output i_pc, i_stall, i_imem_ready, i_br_taken, i_br_target, i_req, i_eret, i_epc,
    input  o_npc, o_pc_en, o_state, o_redir_cnt
  );
  modport slave (
    input  i_pc, i_stall, i_imem_ready, i_br_taken, i_br_target, i_req, i_eret, i_epc,
    output o_npc, o_pc_en, o_state, o_redir_cnt
  );
`else
  modport master (
    output i_pc, i_stall, i_imem_ready, i_br_taken, i_br_target, i_req, i_eret, i_epc,
    input  o_npc, o_pc_en, o_state
  );
  modport slave (
    input  i_pc, i_stall, i_imem_ready, i_br_taken, i_br_target, i_req, i_eret, i_epc,
    output o_npc, o_pc_en, o_state
  );
`endif

endinterface

// File: rtl/npc_pend_buf.sv
// Single-entry pending redirect buffer. Flush beats take beats set; a set while
// already valid is ignored so the oldest redirect wins.
module npc_pend_buf (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_set,
  input  logic [31:0] i_target,
  input  logic        i_take,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_target,
  output logic        o_valid_nxt
);

  logic        valid_q, valid_d;
  logic [31:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (i_flush || i_take) begin
      valid_d = 1'b0;
    end else if (i_set && !valid_q) begin
      valid_d  = 1'b1;
      target_d = i_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_target    = target_q;
  assign o_valid_nxt = valid_d;

endmodule

// File: rtl/npc_sched.sv
// Next-PC scheduler: boot, exception/ERET, deferred and direct branch redirects.
// Defining NPC_PERF_CNT_EN adds a non-sequential fetch counter on o_redir_cnt.
module npc_sched
  import npc_sched_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PcResetDefault,
  parameter logic [31:0] EXC_ENTRY = ExcEntryDefault
) (
  input logic        i_clk,
  input logic        i_reset_n,
  npc_sched_if.slave bus
);

  npc_state_e  state_q, state_d;
  logic        active;
  logic        force_redir;
  logic        pc_en;
  logic [31:0] npc;
  logic [31:0] pc_seq;
  logic        pend_valid;
  logic        pend_valid_nxt;
  logic [31:0] pend_target;
  logic        pend_set;
  logic        pend_take;

  always_comb begin
    pc_seq      = seq_pc(bus.i_pc);
    active      = (state_q == StRun) || (state_q == StHold);
    force_redir = 1'b0;
    pc_en       = 1'b1;
    npc         = PC_RESET;
    pend_set    = 1'b0;
    pend_take   = 1'b0;
    if (active) begin
      force_redir = bus.i_req || bus.i_eret;
      pc_en       = force_redir || (!bus.i_stall && bus.i_imem_ready);
      if (bus.i_req) begin
        npc = EXC_ENTRY;
      end else if (bus.i_eret) begin
        npc = bus.i_epc;
      end else if (pend_valid) begin
        npc = pend_target;
      end else if (bus.i_br_taken) begin
        npc = bus.i_br_target;
      end else begin
        npc = pc_seq;
      end
      // A redirect that cannot load this cycle is parked until fetch is enabled.
      pend_set  = bus.i_br_taken && !pc_en && !force_redir;
      pend_take = pend_valid && pc_en;
    end
    state_d = pend_valid_nxt ? StHold : StRun;
  end

  npc_pend_buf u_pend_buf (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_set       (pend_set),
    .i_target    (bus.i_br_target),
    .i_take      (pend_take),
    .i_flush     (force_redir),
    .o_valid     (pend_valid),
    .o_target    (pend_target),
    .o_valid_nxt (pend_valid_nxt)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.o_npc   = npc;
  assign bus.o_pc_en = pc_en;
  assign bus.o_state = state_q;

`ifdef NPC_PERF_CNT_EN
  logic [31:0] redir_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      redir_cnt_q <= 32'h0;
    end else if (active && pc_en && (npc != pc_seq)) begin
      redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign bus.o_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_npc_sched.sv
// Scoreboard bench for npc_sched: directed vectors push expectations, a negedge monitor checks.
module tb_npc_sched;
  import npc_sched_pkg::*;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        en;
    logic [1:0]  st;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e_m;
  logic [31:0] exp_cnt = 32'h0;

  always #5 i_clk = ~i_clk;

  npc_sched_if bus ();

  npc_sched #(
    .PC_RESET  (32'h0000_3000),
    .EXC_ENTRY (32'h0000_4180)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic [31:0] pc,
                      input logic stall, input logic ready, input logic br,
                      input logic [31:0] tgt, input logic req, input logic eret,
                      input logic [31:0] epc, input logic [31:0] enpc, input logic een,
                      input logic [1:0] est);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_reset_n        = rst;
    bus.i_pc         = pc;
    bus.i_stall      = stall;
    bus.i_imem_ready = ready;
    bus.i_br_taken   = br;
    bus.i_br_target  = tgt;
    bus.i_req        = req;
    bus.i_eret       = eret;
    bus.i_epc        = epc;
    e.name  = name;
    e.rst_n = rst;
    e.pc    = pc;
    e.npc   = enpc;
    e.en    = een;
    e.st    = est;
    exp_q.push_back(e);
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      chk({e_m.name, ".npc"}, bus.o_npc, e_m.npc);
      chk({e_m.name, ".pc_en"}, 32'(bus.o_pc_en), 32'(e_m.en));
      chk({e_m.name, ".state"}, 32'(bus.o_state), 32'(e_m.st));
`ifdef NPC_PERF_CNT_EN
      if (!e_m.rst_n) exp_cnt = 32'h0;
      chk({e_m.name, ".redir_cnt"}, bus.o_redir_cnt, exp_cnt);
      if (e_m.rst_n && e_m.st != 2'd0 && e_m.en && e_m.npc != e_m.pc + 32'd4)
        exp_cnt = exp_cnt + 32'd1;
`endif
    end
  end

  initial begin
    bus.i_pc = 32'h3000; bus.i_stall = 1'b0; bus.i_imem_ready = 1'b1;
    bus.i_br_taken = 1'b0; bus.i_br_target = 32'h0; bus.i_req = 1'b0;
    bus.i_eret = 1'b0; bus.i_epc = 32'h0;
    //   name        rst pc            st rdy br tgt         req er epc         npc           en state
    step("reset",    0, 32'h3000,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3000,     1, 2'd0);
    step("boot",     1, 32'h3000,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3000,     1, 2'd0);
    step("run_seq",  1, 32'h3000,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3004,     1, 2'd1);
    step("br_stall", 1, 32'h3004,     1, 1, 1, 32'h3100,   0, 0, 32'h0,    32'h3100,     0, 2'd1);
    step("hold_ign", 1, 32'h3004,     1, 1, 1, 32'h3200,   0, 0, 32'h0,    32'h3100,     0, 2'd2);
    step("hold_rel", 1, 32'h3004,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3100,     1, 2'd2);
    step("after_rl", 1, 32'h3100,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3104,     1, 2'd1);
    step("br_stl2",  1, 32'h3104,     1, 1, 1, 32'h3300,   0, 0, 32'h0,    32'h3300,     0, 2'd1);
    step("hold_exc", 1, 32'h3104,     1, 1, 0, 32'h0,      1, 0, 32'h0,    32'h4180,     1, 2'd2);
    step("post_exc", 1, 32'h4180,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h4184,     1, 2'd1);
    step("req_eret", 1, 32'h4184,     0, 1, 0, 32'h0,      1, 1, 32'h3020, 32'h4180,     1, 2'd1);
    step("eret_nrd", 1, 32'h4180,     0, 0, 0, 32'h0,      0, 1, 32'h3020, 32'h3020,     1, 2'd1);
    step("not_rdy",  1, 32'h3020,     0, 0, 0, 32'h0,      0, 0, 32'h0,    32'h3024,     0, 2'd1);
    step("br_now",   1, 32'h3020,     0, 1, 1, 32'h3400,   0, 0, 32'h0,    32'h3400,     1, 2'd1);
    step("wrap",     1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,     0, 0, 32'h0,    32'h0000_0000, 1, 2'd1);
    step("br_nrdy",  1, 32'h0,        0, 0, 1, 32'h3500,   0, 0, 32'h0,    32'h3500,     0, 2'd1);
    step("hold_3500",1, 32'h0,        0, 0, 0, 32'h0,      0, 0, 32'h0,    32'h3500,     0, 2'd2);
    step("rst_hold", 0, 32'h0,        0, 0, 0, 32'h0,      0, 0, 32'h0,    32'h3000,     1, 2'd0);
    step("reboot",   1, 32'h0,        0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3000,     1, 2'd0);
    step("no_pend",  1, 32'h3000,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3004,     1, 2'd1);
    step("br_stl3",  1, 32'h3004,     1, 1, 1, 32'h3600,   0, 0, 32'h0,    32'h3600,     0, 2'd1);
    step("hold_ert", 1, 32'h3004,     1, 1, 0, 32'h0,      0, 1, 32'h3040, 32'h3040,     1, 2'd2);
    step("post_ert", 1, 32'h3040,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3044,     1, 2'd1);
    // Fresh reset, then one branch, one exception and ten sequential fetches.
    step("rst_cnt",  0, 32'h3000,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3000,     1, 2'd0);
    step("boot_cnt", 1, 32'h3000,     0, 1, 0, 32'h0,      0, 0, 32'h0,    32'h3000,     1, 2'd0);
    step("cnt_br",   1, 32'h3000,     0, 1, 1, 32'h3100,   0, 0, 32'h0,    32'h3100,     1, 2'd1);
    step("cnt_exc",  1, 32'h3100,     0, 1, 0, 32'h0,      1, 0, 32'h0,    32'h4180,     1, 2'd1);
    for (int i = 0; i < 10; i++) begin
      step("cnt_seq", 1, 32'h4180 + 32'(4 * i), 0, 1, 0, 32'h0, 0, 0, 32'h0,
           32'h4184 + 32'(4 * i), 1, 2'd1);
    end
    @(negedge i_clk);
`ifdef NPC_PERF_CNT_EN
    chk("redir_cnt_total", bus.o_redir_cnt, 32'd2);
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
